pipe_hazard_ctrl: RTL and testbench

// Central stall/flush controller for the N-stage in-order pipeline (stage 0 = PC/IF ... NSTAGE-1 = WB).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_if.sv | 29 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller.
// Stage indices follow the 5-stage pipeline: 0 is youngest (IF), 4 is oldest (WB).
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } stage_e;

    localparam int unsigned CNT_W_DEF = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Request/response bundle between the pipeline stages and the hazard controller.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned CNT_W  = CNT_W_DEF
);

    logic [NSTAGE-1:0] stallreq;
    logic [NSTAGE-1:0] flushreq;
    logic              halt;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              wdog_err;

    modport master (
        output stallreq, flushreq, halt,
        input  stall, bubble, flush, stall_cnt, flush_cnt, wdog_err
    );

    modport slave (
        input  stallreq, flushreq, halt,
        output stall, bubble, flush, stall_cnt, flush_cnt, wdog_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: merges stage stall/redirect requests and debug halt
// into per-stage hold/bubble/flush strobes, with deferred redirects, counters and watchdog.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE   = 5,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned WDOG_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [31:0] WLIM = (WDOG_CYC == 0) ? '0 : 32'(WDOG_CYC - 1);

    logic [NSTAGE-1:0] pend;
    logic [NSTAGE-1:0] pend_d;
    logic [NSTAGE-1:0] raw;
    logic [NSTAGE-1:0] eff_fl;
    logic [NSTAGE-1:0] accept;
    logic [NSTAGE-1:0] kill;
    logic [NSTAGE-1:0] st;
    logic [NSTAGE-1:0] bub;
    logic              racc;
    logic              facc;
    logic              any_acc;
    logic [31:0]       wcnt;
    logic              wdog_err_q;

    always_comb begin
        racc    = 1'b0;
        facc    = 1'b0;
        raw     = '0;
        kill    = '0;
        bub     = '0;
        // Walk oldest to youngest: stall requests propagate to younger stages,
        // and every stage younger than an accepted redirect is killed.
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            racc                = racc | bus.stallreq[NSTAGE-1-k];
            raw[NSTAGE-1-k]     = bus.halt | racc;
        end
        eff_fl = bus.flushreq | pend;
        accept = eff_fl & ~raw;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            kill[NSTAGE-1-k] = facc;
            facc             = facc | accept[NSTAGE-1-k];
        end
        any_acc = facc;
        pend_d  = eff_fl & ~accept & ~kill;
        st      = raw & ~kill;
        for (int unsigned j = 1; j < NSTAGE; j++) begin
            bub[j] = st[j-1] & ~st[j] & ~kill[j];
        end
    end

    assign bus.stall    = rst ? '0 : st;
    assign bus.bubble   = rst ? '0 : bub;
    assign bus.flush    = rst ? '0 : kill;
    assign bus.wdog_err = wdog_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_d;
        end
    end

    // halt freezes the watchdog count rather than clearing it
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt       <= '0;
            wdog_err_q <= 1'b0;
        end else if ((WDOG_CYC != 0) && !bus.halt) begin
            if (st[NSTAGE-1]) begin
                if (wcnt == WLIM) begin
                    wdog_err_q <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end else begin
                wcnt <= '0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (st[NSTAGE-2] & ~rst),
        .cnt (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (any_acc & ~rst),
        .cnt (bus.flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle vector table plus multi-cycle
// sequences for deferred redirects, priority, counters and the watchdog.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sreq;
    logic [4:0] freq;
    logic       halt;
    int         n_cmp  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.NSTAGE(5), .CNT_W(32)) ifm ();
    pipe_hazard_ctrl_if #(.NSTAGE(5), .CNT_W(3))  ifs ();

    assign ifm.stallreq = sreq;
    assign ifm.flushreq = freq;
    assign ifm.halt     = halt;
    assign ifs.stallreq = sreq;
    assign ifs.flushreq = freq;
    assign ifs.halt     = halt;

    pipe_hazard_ctrl #(.NSTAGE(5), .CNT_W(32), .WDOG_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifm.slave)
    );

    pipe_hazard_ctrl #(.NSTAGE(5), .CNT_W(3), .WDOG_CYC(0)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (ifs.slave)
    );

    typedef struct {
        logic [4:0] s;
        logic [4:0] f;
        logic       h;
        logic [4:0] e_stall;
        logic [4:0] e_bubble;
        logic [4:0] e_flush;
    } vec_t;

    vec_t vec [10];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sreq = '0;
        freq = '0;
        halt = 1'b0;
        cyc();
        rst  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec[0] = '{5'b01000, 5'b00000, 1'b0, 5'b01111, 5'b10000, 5'b00000};
        vec[1] = '{5'b00001, 5'b00100, 1'b0, 5'b00000, 5'b00000, 5'b00011};
        vec[2] = '{5'b00000, 5'b01100, 1'b0, 5'b00000, 5'b00000, 5'b00111};
        vec[3] = '{5'b00000, 5'b00000, 1'b1, 5'b11111, 5'b00000, 5'b00000};
        vec[4] = '{5'b00100, 5'b10000, 1'b0, 5'b00000, 5'b00000, 5'b01111};
        vec[5] = '{5'b10000, 5'b01000, 1'b0, 5'b11111, 5'b00000, 5'b00000};
        vec[6] = '{5'b00010, 5'b00001, 1'b0, 5'b00011, 5'b00100, 5'b00000};
        vec[7] = '{5'b00010, 5'b00100, 1'b0, 5'b00000, 5'b00000, 5'b00011};
        vec[8] = '{5'b00000, 5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00000};
        vec[9] = '{5'b00100, 5'b00010, 1'b0, 5'b00111, 5'b01000, 5'b00000};

        // Reset forcing and register clear
        rst  = 1'b1;
        sreq = 5'b11111;
        freq = 5'b10000;
        halt = 1'b0;
        cyc();
        #2;
        chk("rst_stall",  32'(ifm.stall),  32'h0);
        chk("rst_bubble", 32'(ifm.bubble), 32'h0);
        chk("rst_flush",  32'(ifm.flush),  32'h0);
        cyc();
        rst  = 1'b0;
        sreq = '0;
        freq = '0;
        #2;
        chk("rst_pend_flush", 32'(ifm.flush),     32'h0);
        chk("rst_stall_cnt",  ifm.stall_cnt,      32'h0);
        chk("rst_flush_cnt",  ifm.flush_cnt,      32'h0);
        chk("rst_wdog",       32'(ifm.wdog_err),  32'h0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            sreq = vec[i].s;
            freq = vec[i].f;
            halt = vec[i].h;
            #2;
            chk($sformatf("vec%0d_stall", i),  32'(ifm.stall),  32'(vec[i].e_stall));
            chk($sformatf("vec%0d_bubble", i), 32'(ifm.bubble), 32'(vec[i].e_bubble));
            chk($sformatf("vec%0d_flush", i),  32'(ifm.flush),  32'(vec[i].e_flush));
            cyc();
        end

        // stall_cnt counts cycles with stage 3 held
        do_reset();
        sreq = 5'b01000;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            #2;
            chk($sformatf("stall_cnt_%0d", i), ifm.stall_cnt, 32'(i));
        end

        // Redirect blocked by a stall is held until the stage advances
        do_reset();
        sreq = 5'b01000;
        freq = 5'b00100;
        #2;
        chk("defer_c1_flush", 32'(ifm.flush), 32'h0);
        cyc();
        freq = '0;
        for (int i = 2; i <= 3; i++) begin
            #2;
            chk($sformatf("defer_c%0d_flush", i), 32'(ifm.flush), 32'h0);
            cyc();
        end
        sreq = '0;
        #2;
        chk("defer_release_flush", 32'(ifm.flush), 32'h03);
        chk("defer_cnt_before",    ifm.flush_cnt,  32'h0);
        cyc();
        #2;
        chk("defer_pend_cleared", 32'(ifm.flush), 32'h0);
        chk("defer_cnt_after",    ifm.flush_cnt,  32'h1);

        // Oldest redirect wins; pending older redirect plus fresh younger one
        do_reset();
        freq = 5'b01100;
        #2;
        chk("prio_flush", 32'(ifm.flush), 32'h07);
        cyc();
        freq = '0;
        #2;
        chk("prio_pend_clear", 32'(ifm.flush), 32'h0);
        chk("prio_cnt",        ifm.flush_cnt,  32'h1);
        sreq = 5'b01000;
        freq = 5'b01000;
        #2;
        chk("prio_block_flush", 32'(ifm.flush), 32'h0);
        cyc();
        sreq = '0;
        freq = 5'b00010;
        #2;
        chk("prio_pend3_flush", 32'(ifm.flush), 32'h07);
        cyc();
        freq = '0;
        #2;
        chk("prio_pend3_clear", 32'(ifm.flush), 32'h0);
        chk("prio_cnt2",        ifm.flush_cnt,  32'h2);

        // Blocked request on a stage killed by an older redirect is dropped
        do_reset();
        sreq = 5'b00010;
        freq = 5'b10010;
        #2;
        chk("kill_flush", 32'(ifm.flush), 32'h0f);
        chk("kill_stall", 32'(ifm.stall), 32'h0);
        cyc();
        sreq = '0;
        freq = '0;
        #2;
        chk("kill_no_pend", 32'(ifm.flush), 32'h0);

        // Watchdog trips after 4 frozen cycles and is sticky
        do_reset();
        sreq = 5'b10000;
        cyc(); cyc(); cyc();
        #2;
        chk("wdog_c3", 32'(ifm.wdog_err), 32'h0);
        cyc();
        #2;
        chk("wdog_c4", 32'(ifm.wdog_err), 32'h1);
        sreq = '0;
        cyc();
        #2;
        chk("wdog_sticky",   32'(ifm.wdog_err), 32'h1);
        chk("wdog_disabled", 32'(ifs.wdog_err), 32'h0);

        // halt alone never trips; halt in the middle holds the count
        do_reset();
        halt = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        #2;
        chk("halt_no_wdog", 32'(ifm.wdog_err), 32'h0);
        halt = 1'b0;
        sreq = 5'b10000;
        cyc(); cyc();
        halt = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        halt = 1'b0;
        cyc();
        #2;
        chk("halt_hold_c3", 32'(ifm.wdog_err), 32'h0);
        cyc();
        #2;
        chk("halt_hold_c4", 32'(ifm.wdog_err), 32'h1);
        sreq = '0;
        rst  = 1'b1;
        cyc();
        rst  = 1'b0;
        #2;
        chk("wdog_rst_clear", 32'(ifm.wdog_err), 32'h0);

        // Counter saturation on the 3-bit instance
        do_reset();
        sreq = 5'b01000;
        for (int i = 0; i < 9; i++) cyc();
        #2;
        chk("sat_stall_cnt", 32'(ifs.stall_cnt), 32'h7);
        chk("wide_stall_cnt", ifm.stall_cnt,     32'h9);
        sreq = '0;
        freq = 5'b00001;
        for (int i = 0; i < 9; i++) cyc();
        #2;
        chk("sat_flush_cnt", 32'(ifs.flush_cnt), 32'h7);
        chk("sat_stall_hold", 32'(ifs.stall_cnt), 32'h7);
        freq = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
